// File: rtl/mem_access_unit.sv
// Load/store/fetch-and-add controller between the memory-stage request channel
// and a single-port data memory with combinational read and falling-edge write.
module mem_access_unit #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_FAA   = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [1:0]          op_r;
   logic [DATA_W-1:0]   wdata_r;
   logic [DATA_W-1:0]   rdata_r;
   logic [DATA_W-1:0]   din_r;
   logic [ADDR_W-1:0]   addr_r;
   logic                err_r;
   logic                req_err_s;

   // Misaligned, beyond the memory's word range, or a reserved opcode.
   function automatic logic request_error(input logic [31:0] addr, input logic [1:0] op);
      logic bad;
      bad = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0) || (op == OP_RSVD);
      return bad;
   endfunction

   assign req_err_s  = request_error(req_addr, req_op);

   // Handshake strobes and write enable decode straight from the state register.
   assign req_ready  = (state_r == IDLE);
   assign resp_valid = (state_r == RESP);
   assign mem_we     = (state_r == WR);
   assign resp_rdata = rdata_r;
   assign resp_err   = err_r;
   assign mem_addr   = addr_r;
   assign mem_din    = din_r;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               if (req_err_s) begin
                  state_nxt_s = RESP;
               end else if (req_op == OP_STORE) begin
                  state_nxt_s = WR;
               end else begin
                  state_nxt_s = RD;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RD: begin
            if (op_r == OP_FAA) begin
               state_nxt_s = WR;
            end else begin
               state_nxt_s = RESP;
            end
         end
         WR: begin
            state_nxt_s = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Request capture, read-data capture and write-data preparation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r    <= OP_LOAD;
         wdata_r <= '0;
         rdata_r <= '0;
         din_r   <= '0;
         addr_r  <= '0;
         err_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  op_r    <= req_op;
                  wdata_r <= req_wdata;
                  rdata_r <= '0;
                  err_r   <= req_err_s;
                  // A rejected request leaves the memory-side registers untouched.
                  if (!req_err_s) begin
                     addr_r <= req_addr[ADDR_W+1:2];
                     if (req_op == OP_STORE) begin
                        din_r <= req_wdata;
                     end
                  end
               end
            end
            RD: begin
               rdata_r <= mem_dout;
               if (op_r == OP_FAA) begin
                  din_r <= mem_dout + wdata_r;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit with a behavioural
// memory image model and a falling-edge-write data memory.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [4:0]  mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   logic [31:0] mem     [0:31];
   logic [31:0] exp_mem [0:31];
   logic        poke_en = 1'b0;
   logic [4:0]  poke_addr;
   logic [31:0] poke_data;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   // Data memory: combinational read, write on the falling edge.
   assign mem_dout = mem[mem_addr];
   always @(negedge clk) begin
      if (poke_en) mem[poke_addr] <= poke_data;
      else if (mem_we) mem[mem_addr] <= mem_din;
   end

   task automatic poke(input logic [4:0] w, input logic [31:0] v);
      poke_addr = w; poke_data = v; poke_en = 1'b1;
      @(negedge clk); #1;
      poke_en = 1'b0;
      exp_mem[w] = v;
   endtask

   // Reference: expected response, latency and write count from the request rules.
   task automatic model_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic e, output int lat, output int wes);
      logic [4:0] w;
      e = (addr[1:0] != 2'b00) || (addr[31:7] != 25'd0) || (op == 2'b11);
      w = addr[6:2];
      rd = 32'd0; lat = 1; wes = 0;
      if (!e) begin
         case (op)
            2'b00: begin rd = exp_mem[w]; lat = 2; end
            2'b01: begin exp_mem[w] = wd; lat = 2; wes = 1; end
            default: begin rd = exp_mem[w]; exp_mem[w] = rd + wd; lat = 3; wes = 1; end
         endcase
      end
   endtask

   task automatic check_mem(input string name);
      int diffs;
      int first;
      diffs = 0; first = -1;
      for (int i = 0; i < 32; i++) begin
         if (mem[i] !== exp_mem[i]) begin
            diffs++;
            if (first < 0) first = i;
         end
      end
      n_vec++;
      if (diffs != 0) begin
         n_err++;
         $display("FAIL %s mem image: %0d words differ, word %0d got %h want %h",
                  name, diffs, first, mem[first], exp_mem[first]);
      end
   endtask

   task automatic run_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input int stall, input string name);
      logic [31:0] erd;
      logic        eerr;
      int          elat, ewes, lat, wes;
      model_req(op, addr, wd, erd, eerr, elat, ewes);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
      n_vec++;
      if (req_ready !== 1'b1) begin n_err++; $display("FAIL %s req_ready idle: got %b want 1", name, req_ready); end
      @(posedge clk); #1;
      req_valid = 1'b0; req_op = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
      lat = 1; wes = 0;
      while (resp_valid !== 1'b1 && lat < 20) begin
         if (mem_we === 1'b1) wes++;
         @(posedge clk); #1;
         lat++;
      end
      n_vec++;
      if (lat != elat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", name, lat, elat); end
      n_vec++;
      if (resp_rdata !== erd) begin n_err++; $display("FAIL %s rdata: got %h want %h", name, resp_rdata, erd); end
      n_vec++;
      if (resp_err !== eerr) begin n_err++; $display("FAIL %s err: got %b want %b", name, resp_err, eerr); end
      n_vec++;
      if (wes != ewes) begin n_err++; $display("FAIL %s write cycles: got %0d want %0d", name, wes, ewes); end
      n_vec++;
      if (req_ready !== 1'b0) begin n_err++; $display("FAIL %s req_ready busy: got %b want 0", name, req_ready); end
      // Stall with a competing request that must be ignored.
      for (int i = 0; i < stall; i++) begin
         req_valid = 1'b1; req_op = 2'($urandom_range(0, 2));
         req_addr = {25'd0, 5'($urandom_range(0, 31)), 2'b00}; req_wdata = $urandom;
         @(posedge clk); #1;
         n_vec++;
         if (resp_valid !== 1'b1 || resp_rdata !== erd || resp_err !== eerr || req_ready !== 1'b0 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL %s stall: got valid=%b rdata=%h err=%b ready=%b we=%b want 1 %h %b 0 0",
                     name, resp_valid, resp_rdata, resp_err, req_ready, mem_we, erd, eerr);
         end
      end
      req_valid = 1'b0; resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      n_vec++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s release: got valid=%b ready=%b want 0 1", name, resp_valid, req_ready);
      end
      check_mem(name);
   endtask

   task automatic check_reset_outputs(input string name);
      n_vec++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0 ||
          mem_we !== 1'b0 || mem_addr !== 5'd0 || mem_din !== 32'd0) begin
         n_err++;
         $display("FAIL %s outputs: got ready=%b valid=%b err=%b rdata=%h we=%b addr=%h din=%h want 1 0 0 0 0 0 0",
                  name, req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_addr, mem_din);
      end
   endtask

   task automatic test_reset();
      #1;
      check_reset_outputs("reset_asserted");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("reset_released");
   endtask

   task automatic test_load();
      poke(5'd3, 32'd4);
      run_req(2'b00, 32'h0000_000C, 32'h1234_5678, 0, "load_word3");
   endtask

   task automatic test_store_load();
      run_req(2'b01, 32'h0000_0040, 32'hDEAD_BEEF, 0, "store_word16");
      run_req(2'b00, 32'h0000_0040, 32'h0, 0, "load_word16");
   endtask

   task automatic test_faa();
      poke(5'd5, 32'd1);
      run_req(2'b10, 32'h0000_0014, 32'd7, 0, "faa_word5");
      run_req(2'b00, 32'h0000_0014, 32'd0, 0, "load_after_faa");
      poke(5'd9, 32'hFFFF_FFFF);
      run_req(2'b10, 32'h0000_0024, 32'd1, 0, "faa_wrap");
      run_req(2'b00, 32'h0000_0024, 32'd0, 0, "load_after_wrap");
   endtask

   task automatic test_errors();
      run_req(2'b00, 32'h0000_0002, 32'd0, 0, "err_misaligned");
      run_req(2'b00, 32'h0000_0080, 32'd0, 0, "err_out_of_range");
      run_req(2'b11, 32'h0000_0010, 32'hFFFF_FFFF, 0, "err_reserved_op");
      run_req(2'b01, 32'h8000_0000, 32'h5555_5555, 0, "err_store_high");
   endtask

   task automatic test_backpressure();
      poke(5'd7, 32'hA5A5_0F0F);
      run_req(2'b00, 32'h0000_001C, 32'd0, 5, "backpressure_load");
      run_req(2'b10, 32'h0000_001C, 32'd3, 5, "backpressure_faa");
   endtask

   task automatic test_reset_mid();
      req_valid = 1'b1; req_op = 2'b01; req_addr = 32'h0000_0030; req_wdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_vec++;
      if (mem_we !== 1'b1) begin n_err++; $display("FAIL reset_mid in WR: got mem_we=%b want 1", mem_we); end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (mem_we !== 1'b0 || resp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid drop: got we=%b valid=%b want 0 0", mem_we, resp_valid);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("reset_mid_after");
      check_mem("reset_mid");
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [31:0] addr;
      int          r;
      for (int n = 0; n < 60; n++) begin
         op = 2'($urandom_range(0, 3));
         if (op == 2'b11 && $urandom_range(0, 1) == 0) op = 2'b10;
         r = $urandom_range(0, 9);
         addr = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
         if (r == 0) addr[1:0] = 2'($urandom_range(1, 3));
         else if (r == 1) begin
            addr[31:7] = 25'($urandom);
            if (addr[31:7] == 25'd0) addr[20] = 1'b1;
         end
         run_req(op, addr, $urandom, $urandom_range(0, 3), "random");
      end
   endtask

   initial begin
      req_valid = 1'b0; req_op = 2'b00; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
      #2 rst_n = 1'b0;
      for (int i = 0; i < 32; i++) poke(5'(i), $urandom);
      test_reset();
      test_load();
      test_store_load();
      test_faa();
      test_errors();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store controller between the RISC datapath's memory-stage request and the 32x32 data memory (write-enable, 5-bit address, 32-bit write data, combinational read data, write on negedge).
- Accepts one request at a time over a valid/ready handshake and sequences memory read and write cycles.
- Supports load, store and atomic fetch-and-add.
- Returns the result or an error flag over a valid/ready response channel.

Parameters:
- ADDR_W, 5, word-address width of the data memory (depth 2^ADDR_W).
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock; memory samples writes on its falling edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_op  in  2  00 load, 01 store, 10 fetch-and-add, 11 reserved.
- req_addr  in  32  byte address.
- req_wdata  in  DATA_W  store data / add operand.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  DATA_W  load data, or old value for fetch-and-add; 0 for store or error.
- resp_err  out  1  request rejected, no memory access performed.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_din  out  DATA_W  memory write data.
- mem_dout  in  DATA_W  memory read data, combinational from mem_addr.

Behaviour:
- **Reset** (async, rst_n=0):
  - state=IDLE.
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_we=0, mem_addr=0, mem_din=0.
  - mem_we is decoded from state, so it drops immediately when reset asserts mid-operation. Any in-flight request is discarded and no response is issued.
- **States:** IDLE, RD, WR, RESP.
- **IDLE:**
  - req_ready=1.
  - On req_valid, capture op, addr and wdata into registers.
  - Error check:
    - req_addr[1:0]!=0 → misaligned.
    - req_addr[31:ADDR_W+2]!=0 → out of range.
    - op=11 → reserved.
  - Any error → RESP with resp_err=1 and resp_rdata=0; the memory is never touched.
  - Otherwise mem_addr=req_addr[ADDR_W+1:2].
  - Next state: load → RD; store → WR; fetch-and-add → RD.
- **RD:**
  - mem_we=0; mem_addr held.
  - At the rising edge, capture mem_dout into the data register.
  - Next state: load → RESP; fetch-and-add → WR.
- **WR:**
  - mem_we=1 for the full cycle; mem_addr held.
  - mem_din = wdata for store, or captured+wdata (mod 2^DATA_W, carry dropped) for fetch-and-add.
  - The memory commits at the mid-cycle falling edge. Next state → RESP.
- **RESP:**
  - resp_valid=1; resp_rdata and resp_err held stable.
  - On resp_ready → IDLE, with resp_valid cleared the following cycle.
  - A new request is not accepted in the same cycle as the response handshake; req_ready is 0 outside IDLE.
- **Latency** (accept edge to resp_valid high):
  - 2 cycles: load, store.
  - 3 cycles: fetch-and-add.
  - 1 cycle: error.
- **Other rules:**
  - mem_we is 0 in every state except WR.
  - mem_addr and mem_din are registered and change only on request acceptance or on entry to WR.
  - Request inputs are ignored outside IDLE; changing them mid-operation has no effect.
  - resp_ready held low stalls RESP indefinitely, with no memory activity.

Test Plan:
- **Load:** after reset, memory[3]=4; load addr 0x0C → resp_valid 2 cycles after accept, resp_rdata=4, resp_err=0, mem_we never high.
- **Store then load:** store 0xDEADBEEF to addr 0x40 (word 16), then load 0x40 → mem_we high exactly one cycle; load returns 0xDEADBEEF.
- **Fetch-and-add:**
  - memory[5]=1; FAA addr 0x14 wdata 7 → resp_rdata=1 after 3 cycles; a subsequent load returns 8.
  - FAA on 0xFFFFFFFF with wdata 1 → stored value 0.
- **Errors:** load 0x02 (misaligned), load 0x80 (out of range), op=11 → resp_err=1, resp_rdata=0 one cycle after accept, mem_we stays 0, memory unchanged.
- **Backpressure:** hold resp_ready=0 for 5 cycles in RESP → resp_valid and resp_rdata stable, req_ready=0, a new req_valid is ignored; release → IDLE next cycle.
- **Reset mid-operation:** assert rst_n=0 during WR of a store → mem_we falls immediately, no resp_valid; after release req_ready=1 and all outputs are at reset values.
